// File: rtl/if_inst_queue_if.sv
// -----------------------------------------------------------------------------
// if_inst_queue_if
//
// Purpose: groups the fetch-side, instruction-bus and decode-side signals of
// the fetch instruction queue into one bundle.
//
// Modports:
//   slave  - the queue itself. It receives fetch/bus/decode inputs and drives
//            fetch_en, the decode outputs and the inflight debug count.
//   master - the surrounding pipeline (or a testbench). It is the mirror image
//            of slave.
//
// Signals:
//   req_issued      fetch request accepted this cycle
//   data_ok         instruction bus response valid this cycle
//   rdata[31:0]     instruction bus response data
//   PCF[31:0]       PC of the oldest outstanding request
//   InstUnalignedF  unaligned flag paired with PCF
//   flush           pipeline flush
//   fetch_en        fetch may issue a request
//   InstrD[31:0]    instruction to decode
//   PCD[31:0]       PC to decode
//   InstUnalignedD  unaligned flag to decode
//   validD          decode outputs valid
//   readyD          decode accepts the head entry
//   inflight        requests issued but not yet returned
// -----------------------------------------------------------------------------
interface if_inst_queue_if #(
    parameter int CNT_W = 3
);
    logic             req_issued;
    logic             data_ok;
    logic [31:0]      rdata;
    logic [31:0]      PCF;
    logic             InstUnalignedF;
    logic             flush;
    logic             fetch_en;
    logic [31:0]      InstrD;
    logic [31:0]      PCD;
    logic             InstUnalignedD;
    logic             validD;
    logic             readyD;
    logic [CNT_W-1:0] inflight;

    modport slave (
        input  req_issued, data_ok, rdata, PCF, InstUnalignedF, flush, readyD,
        output fetch_en, InstrD, PCD, InstUnalignedD, validD, inflight
    );

    modport master (
        output req_issued, data_ok, rdata, PCF, InstUnalignedF, flush, readyD,
        input  fetch_en, InstrD, PCD, InstUnalignedD, validD, inflight
    );
endinterface

// File: rtl/if_inst_queue.sv
// -----------------------------------------------------------------------------
// if_inst_queue
//
// Purpose: fetch-side instruction queue between the PC/fetch-request stage and
// decode. Each instruction returning on the bus is tagged with its fetch PC and
// unaligned flag, buffered in a DEPTH-entry FIFO and handed to decode through a
// valid/ready handshake. Outstanding requests are counted so that responses to
// flushed fetches are dropped, and fetch is throttled so every outstanding
// response is guaranteed a free slot.
//
// Ports:
//   clk   clock
//   rst   asynchronous, active-low reset
//   bus   if_inst_queue_if.slave (fetch, instruction bus and decode signals)
//
// Parameters:
//   DEPTH  queue entries, power of two, >= 2
//   CNT_W  width of occupancy/in-flight counters, must hold DEPTH
//
// Build option:
//   IF_QUEUE_BYPASS_EN - when defined, a response arriving while the queue is
//   empty (no discard, no flush) is presented to decode in the same cycle, and
//   is only written to the queue if decode does not take it. When undefined,
//   every response goes through the queue and outputs come from storage.
// -----------------------------------------------------------------------------
module if_inst_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    if_inst_queue_if.slave  bus
);
    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   LIMIT_C = (CNT_W+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        unaligned;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] discard_q;

    logic             resp_live;
    logic             dropping;
    logic             q_empty;
    logic             bypass_fire;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   occupancy;
    entry_t           resp_entry;
    entry_t           out_entry;
    logic             out_valid;

    // A response with nothing in flight cannot belong to any request; ignore it.
    assign resp_live = bus.data_ok && (inflight_q != '0);
    assign dropping  = (discard_q != '0);
    assign q_empty   = (count_q == '0);

    // Unaligned fetches carry a nop; the flag still travels with the entry.
    assign resp_entry.instr     = bus.InstUnalignedF ? 32'h0 : bus.rdata;
    assign resp_entry.pc        = bus.PCF;
    assign resp_entry.unaligned = bus.InstUnalignedF;

`ifdef IF_QUEUE_BYPASS_EN
    assign bypass_fire = q_empty && !dropping && !bus.flush && resp_live;
`else
    assign bypass_fire = 1'b0;
`endif

    // A bypassed response taken by decode never needs a queue slot.
    assign push = resp_live && !dropping && !bus.flush && !(bypass_fire && bus.readyD);
    assign pop  = !q_empty && bus.readyD;

    // Issuing only while count + inflight < DEPTH reserves a slot for every
    // outstanding response, so the queue cannot overflow.
    assign occupancy    = {1'b0, count_q} + {1'b0, inflight_q};
    assign bus.fetch_en = rst && !bus.flush && (occupancy < LIMIT_C);
    assign bus.inflight = inflight_q;

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block leaves a value held and no latch is inferred.
    always_comb begin
        out_entry = '0;
        out_valid = 1'b0;
        if (!q_empty) begin
            out_entry = mem[head_q];
            out_valid = 1'b1;
        end else if (bypass_fire) begin
            out_entry = resp_entry;
            out_valid = 1'b1;
        end
    end

    assign bus.validD         = out_valid;
    assign bus.InstrD         = out_entry.instr;
    assign bus.PCD            = out_entry.pc;
    assign bus.InstUnalignedD = out_entry.unaligned;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            case ({bus.req_issued, resp_live})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase

            if (bus.flush) begin
                // Everything still outstanding before this cycle's request
                // belongs to the flushed path; a response arriving now is
                // already accounted for by being dropped.
                head_q    <= '0;
                tail_q    <= '0;
                count_q   <= '0;
                discard_q <= inflight_q - CNT_W'(resp_live);
            end else begin
                if (push) tail_q <= tail_q + 1'b1;
                if (pop)  head_q <= head_q + 1'b1;

                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase

                if (resp_live && dropping) discard_q <= discard_q - 1'b1;
            end
        end
    end

    // NOTE: the entry storage has no reset; validity comes solely from
    // count_q, so stale contents are never observed and the array can map to
    // plain registers or RAM without a reset network.
    always_ff @(posedge clk) begin
        if (push) mem[tail_q] <= resp_entry;
    end

    // Fetch throttling makes this unreachable; firing means the throttle or
    // the in-flight bookkeeping is broken.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst)
        !(push && (count_q == DEPTH_C) && !pop)
    ) else $error("if_inst_queue: push while queue full");

endmodule
